// File: rtl/game_flow_ctrl_if.sv
// Control/status bundle between the game-flow sequencer and its input decoders and display path.
interface game_flow_ctrl_if;
    logic        ctrl_start;
    logic        collision;
    logic        role_reset;
    logic        play_en;
    logic        overdrive;
    logic        gameover;
    logic [1:0]  lives;
    logic [15:0] score_bcd;
    logic [1:0]  state;

    modport master (
        output ctrl_start, collision,
        input  role_reset, play_en, overdrive, gameover, lives, score_bcd, state
    );

    modport slave (
        input  ctrl_start, collision,
        output role_reset, play_en, overdrive, gameover, lives, score_bcd, state
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: title/play/hit/over states, lives, BCD survival score and the
// post-hit overdrive window. All outputs are registered from next-state.
module game_flow_ctrl #(
    parameter int unsigned LIVES_INIT  = 3,
    parameter int unsigned HIT_TICKS   = 200000000,
    parameter int unsigned SCORE_TICKS = 100000000,
    parameter int unsigned OVER_HOLD   = 100000000
) (
    input  logic              clk,
    input  logic              reset,
    game_flow_ctrl_if.slave   bus
);

    localparam logic [1:0] ST_TITLE = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_HIT   = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    localparam int unsigned HW = $clog2(HIT_TICKS + 1);
    localparam int unsigned SW = $clog2(SCORE_TICKS + 1);
    localparam int unsigned OW = $clog2(OVER_HOLD + 1);

    localparam logic [HW-1:0] HIT_RELOAD   = HW'(HIT_TICKS - 1);
    localparam logic [SW-1:0] SCORE_RELOAD = SW'(SCORE_TICKS - 1);
    localparam logic [OW-1:0] HOLD_RELOAD  = OW'(OVER_HOLD - 1);

    logic [1:0]    state_q, state_d;
    logic [1:0]    lives_q, lives_d;
    logic [15:0]   score_q, score_d;
    logic [HW-1:0] hit_tmr_q, hit_tmr_d;
    logic [SW-1:0] score_tmr_q, score_tmr_d;
    logic [OW-1:0] hold_tmr_q, hold_tmr_d;
    logic          start_q;
    logic          role_reset_q, role_reset_d;
    logic          play_en_q, overdrive_q, gameover_q;
    logic          start_rise;

    // Saturating 4-digit BCD increment.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v == 16'h9999) return v;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign start_rise = bus.ctrl_start & ~start_q;

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        score_d      = score_q;
        hit_tmr_d    = hit_tmr_q;
        score_tmr_d  = score_tmr_q;
        hold_tmr_d   = hold_tmr_q;
        role_reset_d = 1'b0;

        // Score runs in both PLAY and HIT, independently of collision handling.
        if (state_q == ST_PLAY || state_q == ST_HIT) begin
            if (score_tmr_q == '0) begin
                score_tmr_d = SCORE_RELOAD;
                score_d     = bcd_inc(score_q);
            end else begin
                score_tmr_d = score_tmr_q - SW'(1);
            end
        end

        case (state_q)
            ST_TITLE: begin
                if (start_rise) begin
                    state_d      = ST_PLAY;
                    lives_d      = 2'(LIVES_INIT);
                    score_d      = '0;
                    score_tmr_d  = SCORE_RELOAD;
                    role_reset_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (bus.collision) begin
                    if (lives_q <= 2'd1) begin
                        state_d    = ST_OVER;
                        lives_d    = 2'd0;
                        hold_tmr_d = HOLD_RELOAD;
                    end else begin
                        state_d   = ST_HIT;
                        lives_d   = lives_q - 2'd1;
                        hit_tmr_d = HIT_RELOAD;
                    end
                end
            end
            ST_HIT: begin
                if (hit_tmr_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    hit_tmr_d = hit_tmr_q - HW'(1);
                end
            end
            default: begin
                if (hold_tmr_q != '0) begin
                    hold_tmr_d = hold_tmr_q - OW'(1);
                end else if (start_rise) begin
                    state_d = ST_TITLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_TITLE;
            lives_q      <= '0;
            score_q      <= '0;
            hit_tmr_q    <= '0;
            score_tmr_q  <= '0;
            hold_tmr_q   <= '0;
            start_q      <= 1'b0;
            role_reset_q <= 1'b0;
            play_en_q    <= 1'b0;
            overdrive_q  <= 1'b0;
            gameover_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            hit_tmr_q    <= hit_tmr_d;
            score_tmr_q  <= score_tmr_d;
            hold_tmr_q   <= hold_tmr_d;
            start_q      <= bus.ctrl_start;
            role_reset_q <= role_reset_d;
            play_en_q    <= (state_d == ST_PLAY) || (state_d == ST_HIT);
            overdrive_q  <= (state_d == ST_HIT) || (state_d == ST_OVER);
            gameover_q   <= (state_d == ST_OVER);
        end
    end

    assign bus.role_reset = role_reset_q;
    assign bus.play_en    = play_en_q;
    assign bus.overdrive  = overdrive_q;
    assign bus.gameover   = gameover_q;
    assign bus.lives      = lives_q;
    assign bus.score_bcd  = score_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with LIVES_INIT=3, HIT_TICKS=10, SCORE_TICKS=4, OVER_HOLD=8.
module tb_game_flow_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    game_flow_ctrl_if bus ();

    game_flow_ctrl #(
        .LIVES_INIT  (3),
        .HIT_TICKS   (10),
        .SCORE_TICKS (4),
        .OVER_HOLD   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; inputs change and outputs are sampled here.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.ctrl_start = 1'b0;
        bus.collision = 1'b0;
        tick(2);
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL reset_state: got %0h want 0", bus.state); end
        checks++; if (bus.lives !== 2'd0) begin errors++; $display("FAIL reset_lives: got %0d want 0", bus.lives); end
        checks++; if (bus.score_bcd !== 16'h0000) begin errors++; $display("FAIL reset_score: got %h want 0000", bus.score_bcd); end
        checks++; if ({bus.role_reset, bus.play_en, bus.overdrive, bus.gameover} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000",
                               {bus.role_reset, bus.play_en, bus.overdrive, bus.gameover});
        end
        reset = 1'b0;
        tick(4);
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL idle_title: got %0h want 0", bus.state); end
    endtask

    // Start key held 20 edges: one role_reset pulse only on the first.
    task automatic test_start();
        int pulses;
        bus.ctrl_start = 1'b1;
        tick();
        checks++; if (bus.role_reset !== 1'b1) begin errors++; $display("FAIL start_pulse: got %b want 1", bus.role_reset); end
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL start_state: got %0h want 1", bus.state); end
        checks++; if (bus.lives !== 2'd3) begin errors++; $display("FAIL start_lives: got %0d want 3", bus.lives); end
        checks++; if (bus.score_bcd !== 16'h0000) begin errors++; $display("FAIL start_score: got %h want 0000", bus.score_bcd); end
        checks++; if (bus.play_en !== 1'b1) begin errors++; $display("FAIL start_play_en: got %b want 1", bus.play_en); end
        pulses = 0;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (bus.role_reset) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL start_retrigger: got %0d extra pulses want 0", pulses); end
        checks++; if (bus.score_bcd !== 16'h0004) begin errors++; $display("FAIL score_19: got %h want 0004", bus.score_bcd); end
        bus.ctrl_start = 1'b0;
    endtask

    task automatic test_score();
        tick(21);
        checks++; if (bus.score_bcd !== 16'h0010) begin errors++; $display("FAIL score_40: got %h want 0010", bus.score_bcd); end
        tick(356);
        checks++; if (bus.score_bcd !== 16'h0099) begin errors++; $display("FAIL score_396: got %h want 0099", bus.score_bcd); end
        tick(3);
        checks++; if (bus.score_bcd !== 16'h0099) begin errors++; $display("FAIL score_399: got %h want 0099", bus.score_bcd); end
        tick();
        checks++; if (bus.score_bcd !== 16'h0100) begin errors++; $display("FAIL score_carry: got %h want 0100", bus.score_bcd); end
    endtask

    // Collision held through HIT must not decrement again; HIT lasts exactly 10 edges.
    task automatic test_hit();
        bus.collision = 1'b1;
        tick();
        checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL hit_state: got %0h want 2", bus.state); end
        checks++; if (bus.lives !== 2'd2) begin errors++; $display("FAIL hit_lives: got %0d want 2", bus.lives); end
        checks++; if (bus.overdrive !== 1'b1) begin errors++; $display("FAIL hit_overdrive: got %b want 1", bus.overdrive); end
        tick(9);
        checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL hit_len: got %0h want 2", bus.state); end
        checks++; if (bus.lives !== 2'd2) begin errors++; $display("FAIL hit_hold_lives: got %0d want 2", bus.lives); end
        tick();
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL hit_exit: got %0h want 1", bus.state); end
        checks++; if (bus.overdrive !== 1'b0) begin errors++; $display("FAIL hit_exit_od: got %b want 0", bus.overdrive); end
        checks++; if (bus.score_bcd !== 16'h0102) begin errors++; $display("FAIL hit_score: got %h want 0102", bus.score_bcd); end
        bus.collision = 1'b0;
    endtask

    task automatic test_gameover();
        bus.collision = 1'b1;
        tick();
        bus.collision = 1'b0;
        checks++; if (bus.lives !== 2'd1) begin errors++; $display("FAIL hit2_lives: got %0d want 1", bus.lives); end
        tick(10);
        checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL hit2_exit: got %0h want 1", bus.state); end
        tick();
        // Final hit lands on a score tick edge: both must take effect.
        bus.collision = 1'b1;
        tick();
        bus.collision = 1'b0;
        checks++; if (bus.state !== 2'b11) begin errors++; $display("FAIL over_state: got %0h want 3", bus.state); end
        checks++; if (bus.lives !== 2'd0) begin errors++; $display("FAIL over_lives: got %0d want 0", bus.lives); end
        checks++; if ({bus.gameover, bus.play_en, bus.overdrive} !== 3'b101) begin
            errors++; $display("FAIL over_flags: got %b want 101", {bus.gameover, bus.play_en, bus.overdrive});
        end
        checks++; if (bus.score_bcd !== 16'h0106) begin errors++; $display("FAIL over_score: got %h want 0106", bus.score_bcd); end
        tick(4);
        checks++; if (bus.score_bcd !== 16'h0106) begin errors++; $display("FAIL over_frozen: got %h want 0106", bus.score_bcd); end
        bus.ctrl_start = 1'b1;
        tick();
        checks++; if (bus.state !== 2'b11) begin errors++; $display("FAIL over_early_start: got %0h want 3", bus.state); end
        bus.ctrl_start = 1'b0;
        tick(2);
        checks++; if (bus.state !== 2'b11) begin errors++; $display("FAIL over_hold: got %0h want 3", bus.state); end
        bus.ctrl_start = 1'b1;
        tick();
        bus.ctrl_start = 1'b0;
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL over_to_title: got %0h want 0", bus.state); end
        checks++; if (bus.gameover !== 1'b0) begin errors++; $display("FAIL title_gameover: got %b want 0", bus.gameover); end
        checks++; if (bus.score_bcd !== 16'h0106) begin errors++; $display("FAIL title_score_hold: got %h want 0106", bus.score_bcd); end
        tick();
    endtask

    task automatic test_saturate();
        bus.ctrl_start = 1'b1;
        tick();
        bus.ctrl_start = 1'b0;
        checks++; if (bus.score_bcd !== 16'h0000) begin errors++; $display("FAIL restart_score: got %h want 0000", bus.score_bcd); end
        checks++; if (bus.lives !== 2'd3) begin errors++; $display("FAIL restart_lives: got %0d want 3", bus.lives); end
        tick(39992);
        checks++; if (bus.score_bcd !== 16'h9998) begin errors++; $display("FAIL sat_9998: got %h want 9998", bus.score_bcd); end
        tick(4);
        checks++; if (bus.score_bcd !== 16'h9999) begin errors++; $display("FAIL sat_9999: got %h want 9999", bus.score_bcd); end
        tick(12);
        checks++; if (bus.score_bcd !== 16'h9999) begin errors++; $display("FAIL sat_hold: got %h want 9999", bus.score_bcd); end
    endtask

    task automatic test_reset_in_hit();
        bus.collision = 1'b1;
        tick();
        bus.collision = 1'b0;
        checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL rst_pre_hit: got %0h want 2", bus.state); end
        tick(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL rst_state: got %0h want 0", bus.state); end
        checks++; if (bus.lives !== 2'd0) begin errors++; $display("FAIL rst_lives: got %0d want 0", bus.lives); end
        checks++; if (bus.score_bcd !== 16'h0000) begin errors++; $display("FAIL rst_score: got %h want 0000", bus.score_bcd); end
        checks++; if ({bus.overdrive, bus.role_reset, bus.play_en} !== 3'b000) begin
            errors++; $display("FAIL rst_flags: got %b want 000", {bus.overdrive, bus.role_reset, bus.play_en});
        end
        tick();
        checks++; if ({bus.state, bus.role_reset} !== 3'b000) begin
            errors++; $display("FAIL rst_after: got %b want 000", {bus.state, bus.role_reset});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.ctrl_start = 1'b0;
        bus.collision = 1'b0;
        test_reset();
        test_start();
        test_score();
        test_hit();
        test_gameover();
        test_saturate();
        test_reset_in_hit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
